alu_ctl_driver: RTL and testbench
=================================

# alu_ctl_driver

Initiator side of the 32-bit ALU control interface: accepts one MIPS instruction plus its register operands per transaction over a valid/ready handshake and decodes it into `ALUctl` and operands. It drives the combinational ALU, captures `ALUOut`/`zero` after one settle cycle, and returns the result over a second valid/ready handshake. It sits between the register-read stage and the existing ALU.

## Interface
- `DATA_W`, 32: operand and result width; fixed at 32 to match the ALU.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: high only in IDLE; combinational from state.
- `req_instr  in  32`: instruction word; [31:26] opcode, [5:0] funct, [15:0] immediate.
- `req_rs_val  in  32`: rs operand.
- `req_rt_val  in  32`: rt operand.
- `alu_a  out  32`: to ALU `a`; registered.
- `alu_b  out  32`: to ALU `b`; registered.
- `alu_ctl  out  4`: to ALU `ALUctl`; registered.
- `alu_out  in  32`: from ALU `ALUOut`.
- `alu_zero  in  2`: from ALU `zero`; only bit 0 is meaningful.
- `rsp_valid  out  1`: response present.
- `rsp_ready  in  1`: consumer accepts the response.
- `rsp_result  out  32`: captured ALU result; 0 when illegal.
- `rsp_zero  out  1`: captured `alu_zero[0]`; 0 when illegal.
- `rsp_illegal  out  1`: instruction not decodable.

## Operation
- States: IDLE, DRIVE, RESP.
  - IDLE: on `req_valid` → DRIVE if the instruction is legal, RESP if illegal.
  - DRIVE: always → RESP.
  - RESP: on `rsp_ready` → IDLE.
- R-type decode (opcode 000000), by funct:
  - 100000 add → 0010
  - 100010 sub → 0110
  - 100100 and → 0000
  - 100101 or → 0001
  - 101010 slt → 0111
  - R-type operands: a = rs, b = rt.
- I-type decode, a = rs in all cases:
  - addi 001000 → 0010, b = sign-extended imm.
  - slti 001010 → 0111, b = sign-extended imm.
  - andi 001100 → 0000, b = zero-extended imm.
  - ori 001101 → 0001, b = zero-extended imm.
  - beq 000100 → 0110, b = rt.
- Illegal instruction (any other encoding):
  - `alu_a`, `alu_b`, `alu_ctl` are not updated.
  - Response is `rsp_illegal`=1, `rsp_result`=0, `rsp_zero`=0.
- Codes outside {0000, 0001, 0010, 0110, 0111} are never driven, except 1100 under the configuration macro.
- Arithmetic is performed entirely by the ALU; the driver does no width extension of results.
- In RESP, all `rsp_*` outputs hold stable until `rsp_ready`.
- A new request is not accepted in the RESP→IDLE transition cycle; `req_ready` rises the cycle after.

## Timing
- Reset values:
  - State IDLE, so `req_ready`=1 during and after reset.
  - `alu_a`=0, `alu_b`=0, `alu_ctl`=0000.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_illegal`=0.
- Legal request accepted at edge E0:
  - `alu_*` are loaded at E0.
  - The ALU settles during the DRIVE cycle.
  - `rsp_result` and `rsp_zero` are captured at E1, and `rsp_valid`=1 after E1. Latency is 2 edges.
- Illegal request accepted at E0: `rsp_valid`=1 after E0. Latency is 1 edge.
- `rsp_ready` high on the first RESP cycle: `rsp_valid` drops at the next edge. Throughput is 1 request per 3 cycles.
- `rsp_ready` asserted outside RESP is ignored.
- Reset mid-transaction abandons it immediately; no response is produced.

## Configuration
- `ALU_CTL_NOR_EN` defined:
  - R-type funct 100111 (nor) decodes to `alu_ctl`=1100, a = rs, b = rt.
  - Requires an ALU build that implements 1100.
- `ALU_CTL_NOR_EN` undefined: funct 100111 is illegal and yields `rsp_illegal`=1.

## Structure
- Package `alu_ctl_pkg` holds:
  - Opcode and funct localparams.
  - The 4-bit `ALUctl` code constants.
  - The state enum.
- Sub-module `alu_ctl_decode`, purely combinational:
  - Input: instruction.
  - Outputs: ctl code, b-select (rt / sext / zext), illegal flag.
- The FSM, operand registers and response registers live in `alu_ctl_driver`.

## Test plan
- add: rs=5, rt=7 → `alu_ctl`=0010, `rsp_result`=12, `rsp_zero`=0, `rsp_valid` 2 cycles after accept.
- beq: rs=rt=0x1234 → `alu_ctl`=0110, `rsp_result`=0, `rsp_zero`=1.
- Immediate extension, rs=0:
  - addi imm=0xFFFF → `alu_b`=0xFFFFFFFF, `rsp_result`=0xFFFFFFFF.
  - ori imm=0xFFFF → `alu_b`=0x0000FFFF.
- Illegal opcode 111111 → `rsp_illegal`=1, `rsp_result`=0, `rsp_valid` 1 cycle after accept, `alu_ctl` unchanged.
- Backpressure:
  - `rsp_ready`=0 for 5 cycles → response held stable and `req_ready`=0 throughout.
  - `rst_n` pulsed during DRIVE → all outputs return to their reset values and `rsp_valid` never asserts.
- nor funct 100111:
  - Macro defined → `alu_ctl`=1100.
  - Macro undefined → `rsp_illegal`=1.

Source files
------------

// File: rtl/alu_ctl_pkg.sv
// Shared encodings for the ALU control driver: MIPS opcode/funct fields,
// 4-bit ALUctl codes, operand-b selection and the driver FSM states.
package alu_ctl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_NOR   = 6'b100111;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        BSEL_RT,
        BSEL_SEXT,
        BSEL_ZEXT
    } bsel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RESP
    } state_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational MIPS decode into ALUctl, operand-b source and illegal flag.
// ALU_CTL_NOR_EN makes R-type nor legal (ALUctl 1100).
module alu_ctl_decode
    import alu_ctl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  ctl,
    output bsel_e       bsel,
    output logic        illegal
);

    logic unused_fields;
    assign unused_fields = ^instr[25:6];

    always_comb begin
        ctl     = CTL_AND;
        bsel    = BSEL_RT;
        illegal = 1'b0;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_ADD:  ctl = CTL_ADD;
                    FN_SUB:  ctl = CTL_SUB;
                    FN_AND:  ctl = CTL_AND;
                    FN_OR:   ctl = CTL_OR;
                    FN_SLT:  ctl = CTL_SLT;
`ifdef ALU_CTL_NOR_EN
                    FN_NOR:  ctl = CTL_NOR;
`else
                    FN_NOR:  illegal = 1'b1;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin ctl = CTL_ADD; bsel = BSEL_SEXT; end
            OP_SLTI: begin ctl = CTL_SLT; bsel = BSEL_SEXT; end
            OP_ANDI: begin ctl = CTL_AND; bsel = BSEL_ZEXT; end
            OP_ORI:  begin ctl = CTL_OR;  bsel = BSEL_ZEXT; end
            OP_BEQ:  ctl = CTL_SUB;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctl_driver.sv
// Initiator for the combinational ALU: request handshake, decode, one settle
// cycle, result capture and response handshake. Honours ALU_CTL_NOR_EN via decode.
module alu_ctl_driver
    import alu_ctl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_instr,
    input  logic [DATA_W-1:0] req_rs_val,
    input  logic [DATA_W-1:0] req_rt_val,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [1:0]        alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal
);

    state_e                    state, state_nxt;
    logic [3:0]                dec_ctl_p0;
    bsel_e                     dec_bsel_p0;
    logic                      dec_ill_p0;
    logic signed [DATA_W-1:0]  b_p0;
    logic                      accept;
    logic                      unused_zero_hi;

    assign unused_zero_hi = alu_zero[1];

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [15:0] imm);
        return DATA_W'(imm);
    endfunction

    function automatic logic signed [DATA_W-1:0] zext_imm(input logic [15:0] imm);
        return $signed({{(DATA_W-16){1'b0}}, imm});
    endfunction

    alu_ctl_decode u_decode (
        .instr   (req_instr),
        .ctl     (dec_ctl_p0),
        .bsel    (dec_bsel_p0),
        .illegal (dec_ill_p0)
    );

    always_comb begin
        b_p0 = $signed(req_rt_val);
        case (dec_bsel_p0)
            BSEL_SEXT: b_p0 = sext_imm($signed(req_instr[15:0]));
            BSEL_ZEXT: b_p0 = zext_imm(req_instr[15:0]);
            default:   b_p0 = $signed(req_rt_val);
        endcase
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = dec_ill_p0 ? ST_RESP : ST_DRIVE;
            end
            ST_DRIVE: state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = req_ready && req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // p0 -> ALU operands: loaded on accept; illegal requests skip straight to a response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctl     <= CTL_AND;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            if (accept && !dec_ill_p0) begin
                alu_a   <= req_rs_val;
                alu_b   <= b_p0;
                alu_ctl <= dec_ctl_p0;
            end
            if (accept && dec_ill_p0) begin
                rsp_result  <= '0;
                rsp_zero    <= 1'b0;
                rsp_illegal <= 1'b1;
            end
            // p1 -> response: ALU has settled for a full cycle
            if (state == ST_DRIVE) begin
                rsp_result  <= alu_out;
                rsp_zero    <= alu_zero[0];
                rsp_illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctl_driver.sv
// Directed + randomized bench for alu_ctl_driver with a behavioural ALU and
// a queue of expected responses.
module tb_alu_ctl_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instr = '0;
    logic [31:0] req_rs_val = '0;
    logic [31:0] req_rt_val = '0;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_out;
    logic [1:0]  alu_zero;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_illegal;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [31:0] last_res;
    logic        last_zero, last_ill;
    int          last_lat;

    always #5 clk = ~clk;

    alu_ctl_driver #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_rs_val(req_rs_val), .req_rt_val(req_rt_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hC: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_ctl, alu_a, alu_b);
    assign alu_zero = {1'b0, (alu_out == 32'd0)};

    function automatic void model(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                                  output logic legal, output logic [3:0] ctl,
                                  output logic [31:0] b, output logic [31:0] res);
        logic [15:0] imm;
        imm   = instr[15:0];
        legal = 1'b1;
        ctl   = 4'h0;
        b     = rt;
        case (instr[31:26])
            6'h00: case (instr[5:0])
                6'h20: ctl = 4'h2;
                6'h22: ctl = 4'h6;
                6'h24: ctl = 4'h0;
                6'h25: ctl = 4'h1;
                6'h2a: ctl = 4'h7;
`ifdef ALU_CTL_NOR_EN
                6'h27: ctl = 4'hC;
`else
                6'h27: legal = 1'b0;
`endif
                default: legal = 1'b0;
            endcase
            6'h08: begin ctl = 4'h2; b = {{16{imm[15]}}, imm}; end
            6'h0a: begin ctl = 4'h7; b = {{16{imm[15]}}, imm}; end
            6'h0c: begin ctl = 4'h0; b = {16'h0, imm}; end
            6'h0d: begin ctl = 4'h1; b = {16'h0, imm}; end
            6'h04: ctl = 4'h6;
            default: legal = 1'b0;
        endcase
        res = alu_fn(ctl, rs, b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt, input int hold);
        exp_t        e;
        logic        legal;
        logic [3:0]  ctl, pc;
        logic [31:0] b, res, pa, pb;
        int          lat;
        model(instr, rs, rt, legal, ctl, b, res);
        e.res  = legal ? res : 32'd0;
        e.zero = legal ? (res == 32'd0) : 1'b0;
        e.ill  = !legal;
        e.lat  = legal ? 2 : 1;
        sb.push_back(e);

        @(negedge clk);
        pa = alu_a; pb = alu_b; pc = alu_ctl;
        chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_instr = instr; req_rs_val = rs; req_rt_val = rt; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        if (legal) begin
            chk({tag, ":alu_ctl"}, 32'(alu_ctl), 32'(ctl));
            chk({tag, ":alu_a"}, alu_a, rs);
            chk({tag, ":alu_b"}, alu_b, b);
        end else begin
            chk({tag, ":alu_ctl_kept"}, 32'(alu_ctl), 32'(pc));
            chk({tag, ":alu_a_kept"}, alu_a, pa);
            chk({tag, ":alu_b_kept"}, alu_b, pb);
        end
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            chk({tag, ":rsp_timeout"}, 32'(rsp_valid), 32'd1);
        end else begin
            last_res = rsp_result; last_zero = rsp_zero; last_ill = rsp_illegal; last_lat = lat;
            chk({tag, ":latency"}, 32'(lat), 32'(e.lat));
            chk({tag, ":result"}, rsp_result, e.res);
            chk({tag, ":zero"}, 32'(rsp_zero), 32'(e.zero));
            chk({tag, ":illegal"}, 32'(rsp_illegal), 32'(e.ill));
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, ":hold_result"}, rsp_result, e.res);
                chk({tag, ":hold_illegal"}, 32'(rsp_illegal), 32'(e.ill));
                chk({tag, ":hold_req_ready"}, 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            #1;
            chk({tag, ":req_ready_in_resp"}, 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            chk({tag, ":valid_drop"}, 32'(rsp_valid), 32'd0);
            chk({tag, ":req_ready_back"}, 32'(req_ready), 32'd1);
        end
    endtask

    logic [5:0]  fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    logic [5:0]  op_tab [5] = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h04};
    logic [31:0] rinstr, ra, rb;
    int          k;

    initial begin
        #2;
        chk("rst:req_ready", 32'(req_ready), 32'd1);
        chk("rst:alu_a", alu_a, 32'd0);
        chk("rst:alu_b", alu_b, 32'd0);
        chk("rst:alu_ctl", 32'(alu_ctl), 32'd0);
        chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst:rsp_result", rsp_result, 32'd0);
        chk("rst:rsp_flags", {30'd0, rsp_zero, rsp_illegal}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst:req_ready", 32'(req_ready), 32'd1);

        send("add", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7, 0);
        chk("add:plan_ctl", 32'(alu_ctl), 32'h2);
        chk("add:plan_result", last_res, 32'd12);
        chk("add:plan_zero", 32'(last_zero), 32'd0);
        chk("add:plan_lat", 32'(last_lat), 32'd2);

        send("beq", {6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1234, 0);
        chk("beq:plan_ctl", 32'(alu_ctl), 32'h6);
        chk("beq:plan_result", last_res, 32'd0);
        chk("beq:plan_zero", 32'(last_zero), 32'd1);

        send("addi", {6'h08, 5'd0, 5'd4, 16'hFFFF}, 32'd0, 32'h55, 0);
        chk("addi:plan_b", alu_b, 32'hFFFF_FFFF);
        chk("addi:plan_result", last_res, 32'hFFFF_FFFF);

        send("ori", {6'h0d, 5'd0, 5'd4, 16'hFFFF}, 32'd0, 32'h55, 0);
        chk("ori:plan_b", alu_b, 32'h0000_FFFF);

        send("illegal", {6'h3f, 26'h0}, 32'd9, 32'd9, 0);
        chk("illegal:plan_ill", 32'(last_ill), 32'd1);
        chk("illegal:plan_result", last_res, 32'd0);
        chk("illegal:plan_lat", 32'(last_lat), 32'd1);
        chk("illegal:plan_ctl", 32'(alu_ctl), 32'h1);

        send("bp_sub", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 32'd100, 32'd58, 5);
        chk("bp_sub:plan_result", last_res, 32'd42);

        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_rdy:rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_rdy:req_ready", 32'(req_ready), 32'd1);
        end
        rsp_ready = 1'b0;

        send("nor", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h27}, 32'hF0F0_0000, 32'h0F0F_0000, 0);
`ifdef ALU_CTL_NOR_EN
        chk("nor:plan_ctl", 32'(alu_ctl), 32'hC);
        chk("nor:plan_result", last_res, 32'h0000_FFFF);
`else
        chk("nor:plan_ill", 32'(last_ill), 32'd1);
`endif

        @(negedge clk);
        req_valid = 1'b1; req_instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
        req_rs_val = 32'd3; req_rt_val = 32'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_mid:in_drive", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid:alu_a", alu_a, 32'd0);
        chk("rst_mid:alu_b", alu_b, 32'd0);
        chk("rst_mid:alu_ctl", 32'(alu_ctl), 32'd0);
        chk("rst_mid:rsp_result", rsp_result, 32'd0);
        chk("rst_mid:rsp_flags", {29'd0, rsp_valid, rsp_zero, rsp_illegal}, 32'd0);
        chk("rst_mid:req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid:no_rsp", 32'(rsp_valid), 32'd0);
        end

        for (int n = 0; n < 12; n++) begin
            k  = $urandom_range(0, 9);
            ra = $urandom;
            rb = (n % 4 == 0) ? ra : $urandom;
            if (k < 5)
                rinstr = {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, fn_tab[k]};
            else
                rinstr = {op_tab[k-5], 5'($urandom), 5'($urandom), 16'($urandom)};
            send("rand", rinstr, ra, rb, n % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
